instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 126 ++++++++++++
 tb/tb_instr_mem_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: takes a 16-bit word-count header and 3-byte instructions
// from a valid/ready byte stream, writes them into instruction memory and then releases the CPU.
//
// state  | meaning
// IDLE   | waiting for start, CPU held in reset
// HDR_HI | waiting for count[15:8]
// HDR_LO | waiting for count[7:0], header legality checked on accept
// B0     | waiting for word[19:16] (low nibble of the byte)
// B1     | waiting for word[15:8]
// B2     | waiting for word[7:0]
// WRITE  | one-cycle memory write strobe
// DONE   | load complete, CPU released
// ERROR  | illegal header, CPU stays held
module instr_mem_loader #(
    parameter int DEPTH = 512,
    parameter int AW    = 15,
    parameter int DW    = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    // addr must be wide enough both to drive wa and to compare against the 16-bit count
    localparam int CW = (AW > 16) ? AW : 16;
    localparam logic [16:0] DEPTH_V = 17'(DEPTH);

    typedef enum logic [3:0] {
        IDLE, HDR_HI, HDR_LO, B0, B1, B2, WRITE, DONE, ERROR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   count;
    logic [CW-1:0] addr;
    logic [3:0]    b0;
    logic [7:0]    b1;
    logic          accept;
    logic [15:0]   hdr;
    logic          last;

    assign accept = rx_valid && rx_ready;
    assign hdr    = {count[15:8], rx_data};
    assign last   = (addr == (CW'(count) - CW'(1)));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = HDR_HI;
            HDR_HI:  if (accept) state_nxt = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (hdr == 16'd0 || {1'b0, hdr} > DEPTH_V)
                        state_nxt = ERROR;
                    else
                        state_nxt = B0;
                end
            end
            B0:      if (accept) state_nxt = B1;
            B1:      if (accept) state_nxt = B2;
            B2:      if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = last ? DONE : B0;
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            addr      <= '0;
            b0        <= '0;
            b1        <= '0;
            rx_ready  <= 1'b0;
            we        <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_ready  <= state_nxt inside {HDR_HI, HDR_LO, B0, B1, B2};
            busy      <= state_nxt inside {HDR_HI, HDR_LO, B0, B1, B2, WRITE};
            we        <= (state_nxt == WRITE);
            cpu_reset <= (state_nxt == DONE);
            done      <= (state_nxt == DONE);
            error     <= (state_nxt == ERROR);

            if (accept) begin
                case (state)
                    HDR_HI: count[15:8] <= rx_data;
                    HDR_LO: begin
                        count[7:0] <= rx_data;
                        addr       <= '0;
                    end
                    B0:     b0 <= rx_data[3:0];
                    B1:     b1 <= rx_data;
                    B2: begin
                        wa <= addr[AW-1:0];
                        wd <= DW'({b0, b1, rx_data});
                    end
                    default: ;
                endcase
            end

            if (state == WRITE && !last)
                addr <= addr + CW'(1);
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as bytes are sent
// and popped by a monitor on every observed write strobe.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        we;
    logic [14:0] wa;
    logic [19:0] wd;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    logic [14:0] last_wa = '0;
    logic [34:0] exp_q[$];

    instr_mem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic run_monitor();
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                we_cnt++;
                last_wa = wa;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_we got wa=%0d wd=%05h expected no write", wa, wd);
                end else begin
                    e = exp_q.pop_front();
                    if ({wa, wd} !== e) begin
                        errors++;
                        $display("FAIL write_word got wa=%0d wd=%05h expected wa=%0d wd=%05h",
                                 wa, wd, e[34:20], e[19:0]);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data = 8'($urandom);
        end
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (rx_ready === 1'b1) begin
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
                rx_data = 8'($urandom);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout got rx_ready=%b expected 1 within 50 cycles", rx_ready);
        rx_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    endfunction

    task automatic send_word(input logic [19:0] w, input logic [14:0] a, input int maxgap);
        exp_q.push_back({a, w});
        send_byte({4'($urandom), w[19:16]}, pick_gap(maxgap));
        send_byte(w[15:8], pick_gap(maxgap));
        send_byte(w[7:0], pick_gap(maxgap));
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, we, wa, wd, cpu_reset, busy, done, error} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs got %011h expected 0", {rx_ready, we, wa, wd, cpu_reset, busy, done, error});
        end
        start = 1'b0;
        rx_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_start_in_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rx_ready} !== 2'b00) begin
            errors++;
            $display("FAIL start_in_reset got busy=%b rx_ready=%b expected 0 0", busy, rx_ready);
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_reset_after got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_two_word();
        logic [7:0] bytes[8] = '{8'h00, 8'h02, 8'h0A, 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45};
        int base;
        do_reset();
        base = we_cnt;
        pulse_start();
        checks++;
        if ({busy, rx_ready, cpu_reset} !== 3'b110) begin
            errors++;
            $display("FAIL two_word_started got busy=%b rx_ready=%b cpu_reset=%b expected 1 1 0",
                     busy, rx_ready, cpu_reset);
        end
        exp_q.push_back({15'd0, 20'hABCDE});
        exp_q.push_back({15'd1, 20'h12345});
        foreach (bytes[i]) send_byte(bytes[i], 0);
        @(posedge clk);
        #1;
        checks++;
        if ({done, cpu_reset, busy, error, we} !== 5'b11000) begin
            errors++;
            $display("FAIL two_word_done got done=%b cpu_reset=%b busy=%b error=%b we=%b expected 1 1 0 0 0",
                     done, cpu_reset, busy, error, we);
        end
        @(negedge clk);
        checks++;
        if (we_cnt - base != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL two_word_count got writes=%0d pending=%0d expected 2 0", we_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_bad_header(input logic [7:0] hi, input logic [7:0] lo);
        int base;
        do_reset();
        base = we_cnt;
        pulse_start();
        send_byte(hi, 0);
        send_byte(lo, 0);
        checks++;
        if ({error, done, cpu_reset, busy, rx_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL bad_header_%02h%02h got error=%b done=%b cpu_reset=%b busy=%b rx_ready=%b expected 1 0 0 0 0",
                     hi, lo, error, done, cpu_reset, busy, rx_ready);
        end
        repeat (3) @(negedge clk);
        pulse_start();
        @(negedge clk);
        checks++;
        if ({error, busy, we_cnt - base} !== {2'b10, 32'd0}) begin
            errors++;
            $display("FAIL bad_header_sticky got error=%b busy=%b writes=%0d expected 1 0 0",
                     error, busy, we_cnt - base);
        end
    endtask

    task automatic test_gaps();
        int base;
        do_reset();
        base = we_cnt;
        pulse_start();
        send_byte(8'h00, pick_gap(4));
        send_byte(8'h03, pick_gap(4));
        for (int i = 0; i < 3; i++) send_word(20'($urandom), 15'(i), 4);
        for (int n = 0; n < 20 && done !== 1'b1; n++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || we_cnt - base != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gaps_load got done=%b writes=%0d pending=%0d expected 1 3 0",
                     done, we_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [19:0] w;
        do_reset();
        base = we_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h0A, 0);
        for (int i = 0; i < 4; i++) send_word(20'($urandom), 15'(i), 1);
        w = 20'($urandom);
        send_byte({4'h0, w[19:16]}, 0);
        send_byte(w[15:8], 0);
        @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b1;
        rx_data = w[7:0];
        @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, we, wa, wd, cpu_reset, busy, done, error} !== 41'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %011h expected 0", {rx_ready, we, wa, wd, cpu_reset, busy, done, error});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (we_cnt - base != 4 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_writes got writes=%0d busy=%b pending=%0d expected 4 0 0",
                     we_cnt - base, busy, exp_q.size());
        end
    endtask

    task automatic test_full_depth();
        int base;
        do_reset();
        base = we_cnt;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 512; i++) send_word(20'($urandom), 15'(i), 0);
        for (int n = 0; n < 5 && done !== 1'b1; n++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || last_wa !== 15'd511 || we_cnt - base != 512) begin
            errors++;
            $display("FAIL full_depth got done=%b last_wa=%0d writes=%0d expected 1 511 512",
                     done, last_wa, we_cnt - base);
        end
        pulse_start();
        @(negedge clk);
        checks++;
        if ({done, cpu_reset, busy, rx_ready} !== 4'b1100 || we_cnt - base != 512) begin
            errors++;
            $display("FAIL start_in_done got done=%b cpu_reset=%b busy=%b rx_ready=%b writes=%0d expected 1 1 0 0 512",
                     done, cpu_reset, busy, rx_ready, we_cnt - base);
        end
    endtask

    initial begin
        fork
            run_monitor();
            begin
                #2000000;
                $display("FAIL watchdog got no finish expected finish before time limit");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_start_in_reset();
        test_two_word();
        test_bad_header(8'h00, 8'h00);
        test_bad_header(8'h02, 8'h01);
        test_gaps();
        test_reset_mid();
        test_full_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
